// File: rtl/sha256_w_schedule_streamer_if.sv
// rtl/sha256_w_schedule_streamer_if.sv - block-in / schedule-word-out handshake bundle
interface sha256_w_schedule_streamer_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_block;
  logic         pad_mode;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_index;
  logic         w_last;

  // Producer-side view: the streamer itself
  modport slave (
    input  in_valid, in_block, pad_mode, w_ready,
    output in_ready, w_valid, w_data, w_index, w_last
  );

  // Environment view: block assembler plus round datapath
  modport master (
    output in_valid, in_block, pad_mode, w_ready,
    input  in_ready, w_valid, w_data, w_index, w_last
  );
endinterface

// File: rtl/sha256_w_schedule_streamer.sv
// rtl/sha256_w_schedule_streamer.sv - serial SHA-256 W0..W63 producer, optional SECOND_HASH_PAD_EN digest padding
module sha256_w_schedule_streamer #(
  parameter int MAX_ROUND = 63
) (
  input  logic CLK,
  input  logic RST,
  sha256_w_schedule_streamer_if.slave bus,
  output logic busy
);

  localparam logic [5:0] LAST = 6'(MAX_ROUND);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] win [16];
  logic [31:0] load_w [16];
  logic [31:0] w_new;
  logic [5:0]  t_q;
  logic        in_ready_q;
  logic        w_valid_q;
  logic        w_last_q;
  logic        accept;
  logic        advance;
  logic        done;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign accept  = bus.in_valid & in_ready_q & (state == IDLE);
  assign advance = w_valid_q & bus.w_ready;
  assign done    = advance & (t_q == LAST);
  assign w_new   = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  assign bus.in_ready = in_ready_q;
  assign bus.w_valid  = w_valid_q;
  assign bus.w_data   = win[0];
  assign bus.w_index  = t_q;
  assign bus.w_last   = w_last_q;
  assign busy         = (state == RUN);

  // Block-to-window load mux; digest padding replaces the upper half of the window
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      load_w[k] = bus.in_block[511 - 32*k -: 32];
    end
`ifdef SECOND_HASH_PAD_EN
    if (bus.pad_mode) begin
      for (int k = 8; k < 16; k++) begin
        load_w[k] = 32'h0;
      end
      load_w[8]  = 32'h8000_0000;
      load_w[15] = 32'h0000_0100;
    end
`endif
  end

`ifndef SECOND_HASH_PAD_EN
  logic unused_pad_mode;
  assign unused_pad_mode = bus.pad_mode;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: accept a block in IDLE, return after the final word handshakes
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered handshake flags and round counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      in_ready_q <= 1'b0;
      w_valid_q  <= 1'b0;
      w_last_q   <= 1'b0;
      t_q        <= 6'd0;
    end else begin
      in_ready_q <= (state_nxt == IDLE);
      w_valid_q  <= (state_nxt == RUN);
      if (accept) begin
        t_q      <= 6'd0;
        w_last_q <= (LAST == 6'd0);
      end else if (done) begin
        t_q      <= 6'd0;
        w_last_q <= 1'b0;
      end else if (advance) begin
        t_q      <= t_q + 6'd1;
        w_last_q <= ((t_q + 6'd1) == LAST);
      end
    end
  end

  // Sliding 16-word window; win[0] is the word on offer
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < 16; k++) win[k] <= 32'h0;
    end else if (accept) begin
      for (int k = 0; k < 16; k++) win[k] <= load_w[k];
    end else if (advance && !done) begin
      for (int k = 0; k < 15; k++) win[k] <= win[k+1];
      win[15] <= w_new;
    end
  end

endmodule
